scytale_decryption: RTL and testbench

Downstream consumer of the decryption register file's `scytale_key` output. It buffers an incoming ciphertext byte stream until the start-decryption token arrives. It then emits the plaintext as a stride-permuted read of the buffer. It sits in the Scytale lane between the input DEMUX and the output MUX, and reports `busy` so the data source stalls while output is in progress.

---
 rtl/scytale_decryption.sv | 96 +++++++++
 tb/tb_scytale_decryption.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/scytale_decryption.sv
// Scytale lane decryptor: buffers ciphertext until the start token, then
// replays the buffer as a stride-permuted read while holding busy high.
module scytale_decryption #(
   parameter int                   D_WIDTH                = 8,
   parameter int                   KEY_WIDTH              = 8,
   parameter int                   MAX_NOF_CHARS          = 50,
   parameter logic [D_WIDTH-1:0]   START_DECRYPTION_TOKEN = 8'hFA
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [D_WIDTH-1:0]   data_i,
   input  logic                 valid_i,
   input  logic [KEY_WIDTH-1:0] key_N,
   output logic [D_WIDTH-1:0]   data_o,
   output logic                 valid_o,
   output logic                 busy
);

   localparam int CW = $clog2(MAX_NOF_CHARS + 1);

   localparam logic [0:0] COLLECT = 1'b0;
   localparam logic [0:0] DECRYPT = 1'b1;

   logic [0:0]         state;
   logic [D_WIDTH-1:0] char_buf [MAX_NOF_CHARS];
   logic [CW-1:0]      cnt;
   logic [CW-1:0]      len;
   logic [CW-1:0]      out_cnt;
   logic [CW-1:0]      idx;
   logic [CW-1:0]      stride;
   logic [CW:0]        next_idx;
   logic               is_token;
   logic               buf_full;
   logic               key_degenerate;

   assign is_token       = (data_i == START_DECRYPTION_TOKEN);
   assign buf_full       = (cnt == CW'(MAX_NOF_CHARS));
   assign next_idx       = {1'b0, idx} + {1'b0, stride};
   // A zero key or one not shorter than the message cannot form columns,
   // so it collapses to a straight pass-through read.
   assign key_degenerate = (key_N == '0) || (int'(key_N) >= int'(cnt));

   always_ff @(posedge clk) begin
      if (state == COLLECT && valid_i && !is_token && !buf_full) begin
         char_buf[cnt] <= data_i;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= COLLECT;
         cnt     <= '0;
         len     <= '0;
         out_cnt <= '0;
         idx     <= '0;
         stride  <= '0;
         data_o  <= '0;
         valid_o <= 1'b0;
         busy    <= 1'b0;
      end else if (state == COLLECT) begin
         valid_o <= 1'b0;
         data_o  <= '0;
         if (valid_i) begin
            if (is_token) begin
               stride  <= key_degenerate ? CW'(1) : CW'(key_N);
               len     <= cnt;
               idx     <= '0;
               out_cnt <= '0;
               busy    <= 1'b1;
               state   <= DECRYPT;
            end else if (!buf_full) begin
               cnt <= cnt + CW'(1);
            end
         end
      end else begin
         // Wrapping past the end moves to the start of the next column.
         if (out_cnt < len) begin
            data_o  <= char_buf[idx];
            valid_o <= 1'b1;
            out_cnt <= out_cnt + CW'(1);
            if (next_idx >= {1'b0, len}) begin
               idx <= CW'(next_idx - {1'b0, len} + (CW+1)'(1));
            end else begin
               idx <= CW'(next_idx);
            end
         end else begin
            data_o  <= '0;
            valid_o <= 1'b0;
            busy    <= 1'b0;
            cnt     <= '0;
            state   <= COLLECT;
         end
      end
   end

endmodule

// File: tb/tb_scytale_decryption.sv
// Randomised and directed bench for scytale_decryption against a queue-based
// model of the stride-permuted read.
module tb_scytale_decryption;

   localparam int         MAXC  = 50;
   localparam logic [7:0] TOKEN = 8'hFA;

   logic       clk;
   logic       rst_n;
   logic [7:0] data_i;
   logic       valid_i;
   logic [7:0] key_N;
   logic [7:0] data_o;
   logic       valid_o;
   logic       busy;

   int compared;
   int mismatched;

   scytale_decryption #(
      .D_WIDTH(8), .KEY_WIDTH(8), .MAX_NOF_CHARS(MAXC), .START_DECRYPTION_TOKEN(TOKEN)
   ) dut (
      .clk(clk), .rst_n(rst_n), .data_i(data_i), .valid_i(valid_i), .key_N(key_N),
      .data_o(data_o), .valid_o(valid_o), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: keep the first MAXC characters, then walk the buffer by the
   // effective stride, wrapping to (next - len + 1).
   function automatic void model(input logic [7:0] chars[$], input int key, output logic [7:0] exp[$]);
      int len, s, ix, nx;
      exp = {};
      len = (chars.size() > MAXC) ? MAXC : chars.size();
      s = (key == 0 || key >= len) ? 1 : key;
      ix = 0;
      for (int k = 0; k < len; k++) begin
         exp.push_back(chars[ix]);
         nx = ix + s;
         ix = (nx >= len) ? nx - len + 1 : nx;
      end
   endfunction

   task automatic send_chars(input logic [7:0] chars[$]);
      foreach (chars[i]) begin
         data_i = chars[i]; valid_i = 1'b1;
         @(negedge clk);
      end
      valid_i = 1'b0; data_i = 8'h00;
   endtask

   // Sends the token and records every sample until busy falls.
   // disturb: 1 = junk data and tokens while busy, 2 = key change while busy.
   task automatic run_message(input logic [7:0] key, input int disturb, input int explen,
                              output logic [7:0] got[$], output int busy_cyc,
                              output int first_lat, output int idle_nz, output bit timeout);
      got = {}; busy_cyc = 0; first_lat = -1; idle_nz = 0; timeout = 1'b1;
      data_i = TOKEN; valid_i = 1'b1; key_N = key;
      @(negedge clk);
      valid_i = 1'b0; data_i = 8'h00;
      for (int i = 0; i < 200; i++) begin
         if (!valid_o && data_o !== 8'h00) idle_nz++;
         if (valid_o) begin
            if (first_lat < 0) first_lat = i;
            got.push_back(data_o);
         end
         if (!busy) begin
            timeout = 1'b0;
            break;
         end
         busy_cyc++;
         valid_i = 1'b0;
         if (disturb == 1 && i < explen) begin
            valid_i = 1'b1; data_i = (i % 2 == 1) ? TOKEN : 8'h5A;
         end else if (disturb == 2) begin
            key_N = 8'd3;
         end
         @(negedge clk);
      end
      valid_i = 1'b0; data_i = 8'h00;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; valid_i = 1'b0; data_i = 8'h00; key_N = 8'hFF;
      #12;
      compared++;
      if ({data_o, valid_o, busy} !== 10'b0) begin
         mismatched++;
         $display("[TB] FAIL reset_outputs: got data=%0h valid=%0b busy=%0b expected all 0", data_o, valid_o, busy);
      end
      @(negedge clk); rst_n = 1'b1; @(negedge clk);
   endtask

   task automatic test_stride(input string name, input logic [7:0] key);
      logic [7:0] chars[$], exp[$], got[$];
      int bc, fl, inz; bit to;
      chars = {8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46};
      send_chars(chars);
      model(chars, int'(key), exp);
      run_message(key, 0, exp.size(), got, bc, fl, inz, to);
      compared++; if (to) begin mismatched++; $display("[TB] FAIL %s_timeout: busy never fell", name); end
      compared++; if (got.size() != exp.size()) begin mismatched++; $display("[TB] FAIL %s_count: got %0d expected %0d", name, got.size(), exp.size()); end
      foreach (exp[k]) begin
         compared++;
         if (k >= got.size() || got[k] !== exp[k]) begin mismatched++; $display("[TB] FAIL %s_char%0d: got %0h expected %0h", name, k, (k < got.size()) ? got[k] : 8'hxx, exp[k]); end
      end
      compared++; if (bc != 7) begin mismatched++; $display("[TB] FAIL %s_busy: got %0d cycles expected 7", name, bc); end
      compared++; if (fl != 1) begin mismatched++; $display("[TB] FAIL %s_latency: got %0d expected 1", name, fl); end
      compared++; if (inz != 0) begin mismatched++; $display("[TB] FAIL %s_idle_data: got %0d nonzero idle samples expected 0", name, inz); end
   endtask

   task automatic test_empty_and_ignored();
      logic [7:0] chars[$], exp[$], got[$];
      int bc, fl, inz; bit to;
      run_message(8'd2, 0, 0, got, bc, fl, inz, to);
      compared++; if (to || got.size() != 0) begin mismatched++; $display("[TB] FAIL empty_count: got %0d outputs expected 0", got.size()); end
      compared++; if (bc != 1) begin mismatched++; $display("[TB] FAIL empty_busy: got %0d cycles expected 1", bc); end
      chars = {8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46};
      send_chars(chars);
      model(chars, 2, exp);
      run_message(8'd2, 1, exp.size(), got, bc, fl, inz, to);
      compared++; if (to || got.size() != exp.size()) begin mismatched++; $display("[TB] FAIL ignored_count: got %0d expected %0d", got.size(), exp.size()); end
      foreach (exp[k]) begin
         compared++;
         if (k >= got.size() || got[k] !== exp[k]) begin mismatched++; $display("[TB] FAIL ignored_char%0d: got %0h expected %0h", k, (k < got.size()) ? got[k] : 8'hxx, exp[k]); end
      end
      run_message(8'd2, 0, 0, got, bc, fl, inz, to);
      compared++; if (to || got.size() != 0 || bc != 1) begin mismatched++; $display("[TB] FAIL ignored_nothing_stored: got %0d outputs %0d busy expected 0 and 1", got.size(), bc); end
   endtask

   task automatic test_overflow();
      logic [7:0] chars[$], got[$];
      int bc, fl, inz; bit to;
      chars = {};
      for (int i = 0; i < 52; i++) chars.push_back(8'(i));
      send_chars(chars);
      run_message(8'd1, 0, MAXC, got, bc, fl, inz, to);
      compared++; if (to || got.size() != MAXC) begin mismatched++; $display("[TB] FAIL overflow_count: got %0d expected %0d", got.size(), MAXC); end
      for (int k = 0; k < MAXC; k++) begin
         compared++;
         if (k >= got.size() || got[k] !== 8'(k)) begin mismatched++; $display("[TB] FAIL overflow_char%0d: got %0h expected %0h", k, (k < got.size()) ? got[k] : 8'hxx, k); end
      end
      compared++; if (bc != MAXC + 1) begin mismatched++; $display("[TB] FAIL overflow_busy: got %0d expected %0d", bc, MAXC + 1); end
   endtask

   task automatic test_key_change();
      logic [7:0] chars[$], exp[$], got[$];
      int bc, fl, inz; bit to;
      chars = {8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46};
      send_chars(chars);
      model(chars, 2, exp);
      run_message(8'd2, 2, exp.size(), got, bc, fl, inz, to);
      compared++; if (to || got.size() != exp.size()) begin mismatched++; $display("[TB] FAIL keychg_count: got %0d expected %0d", got.size(), exp.size()); end
      foreach (exp[k]) begin
         compared++;
         if (k >= got.size() || got[k] !== exp[k]) begin mismatched++; $display("[TB] FAIL keychg_char%0d: got %0h expected %0h", k, (k < got.size()) ? got[k] : 8'hxx, exp[k]); end
      end
   endtask

   task automatic test_reset_mid_decrypt();
      logic [7:0] chars[$], exp[$], got[$];
      int bc, fl, inz, seen; bit to;
      chars = {8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46};
      send_chars(chars);
      model(chars, 2, exp);
      data_i = TOKEN; valid_i = 1'b1; key_N = 8'd2;
      @(negedge clk);
      valid_i = 1'b0; data_i = 8'h00;
      seen = 0;
      for (int i = 0; i < 20 && seen < 3; i++) begin
         if (valid_o) seen++;
         if (seen < 3) @(negedge clk);
      end
      compared++; if (seen != 3 || data_o !== exp[2]) begin mismatched++; $display("[TB] FAIL rstmid_third: got %0h after %0d outputs expected %0h", data_o, seen, exp[2]); end
      rst_n = 1'b0;
      #1;
      compared++;
      if ({data_o, valid_o, busy} !== 10'b0) begin
         mismatched++;
         $display("[TB] FAIL rstmid_async: got data=%0h valid=%0b busy=%0b expected all 0", data_o, valid_o, busy);
      end
      @(negedge clk); rst_n = 1'b1; @(negedge clk);
      chars = {8'h58, 8'h59};
      send_chars(chars);
      run_message(8'd1, 0, 2, got, bc, fl, inz, to);
      compared++; if (to || got.size() != 2) begin mismatched++; $display("[TB] FAIL rstmid_count: got %0d expected 2", got.size()); end
      compared++; if (got.size() != 2 || got[0] !== 8'h58 || got[1] !== 8'h59) begin mismatched++; $display("[TB] FAIL rstmid_xy: got %p expected 58 59", got); end
   endtask

   task automatic test_random();
      logic [7:0] chars[$], exp[$], got[$], c, key;
      int n, bc, fl, inz, pick; bit to;
      for (int it = 0; it < 8; it++) begin
         n = $urandom_range(0, 55);
         chars = {};
         for (int i = 0; i < n; i++) begin
            c = 8'($urandom_range(0, 255));
            if (c == TOKEN) c = 8'h3C;
            chars.push_back(c);
         end
         pick = $urandom_range(0, 3);
         key = (pick == 0) ? 8'h00 : (pick == 1) ? 8'hFF : (pick == 2) ? 8'($urandom_range(1, 8)) : 8'($urandom_range(0, 255));
         send_chars(chars);
         model(chars, int'(key), exp);
         run_message(key, 0, exp.size(), got, bc, fl, inz, to);
         compared++; if (to || got.size() != exp.size()) begin mismatched++; $display("[TB] FAIL rand%0d_count: got %0d expected %0d (key %0h)", it, got.size(), exp.size(), key); end
         foreach (exp[k]) begin
            compared++;
            if (k >= got.size() || got[k] !== exp[k]) begin mismatched++; $display("[TB] FAIL rand%0d_char%0d: got %0h expected %0h (key %0h)", it, k, (k < got.size()) ? got[k] : 8'hxx, exp[k], key); end
         end
         compared++; if (bc != exp.size() + 1) begin mismatched++; $display("[TB] FAIL rand%0d_busy: got %0d expected %0d", it, bc, exp.size() + 1); end
         compared++; if (inz != 0) begin mismatched++; $display("[TB] FAIL rand%0d_idle_data: got %0d nonzero idle samples expected 0", it, inz); end
      end
   endtask

   initial begin
      compared = 0;
      mismatched = 0;
      test_reset();
      test_stride("stride2", 8'd2);
      test_stride("stride3", 8'd3);
      test_stride("key0", 8'd0);
      test_stride("keyFF", 8'hFF);
      test_empty_and_ignored();
      test_overflow();
      test_key_change();
      test_reset_mid_decrypt();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
